// File: rtl/demux1to2_5bits_stream.sv
// Registered 1-to-2 stream demultiplexer: each input word is steered by in_sel into one of
// two independent single-entry output registers, each with its own delivered-word counter.
module demux1to2_5bits_stream #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
);

  logic free0, free1;
  logic accept, load0, load1;
  logic deliver0, deliver1;

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] cnt);
    wrap_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A channel can take a word when empty, or when its current word leaves this cycle.
  assign free0    = !out0_valid || out0_ready;
  assign free1    = !out1_valid || out1_ready;
  assign in_ready = !reset && (in_sel ? free1 : free0);

  assign accept   = in_valid && in_ready;
  assign load0    = accept && !in_sel;
  assign load1    = accept && in_sel;
  assign deliver0 = out0_valid && out0_ready;
  assign deliver1 = out1_valid && out1_ready;

  // Output register stage, channel 0
  always_ff @(posedge clk) begin
    if (reset) begin
      out0_data  <= '0;
      out0_valid <= 1'b0;
      out0_count <= '0;
    end else begin
      if (load0) begin
        out0_data  <= in_data;
        out0_valid <= 1'b1;
      end else if (deliver0) begin
        out0_valid <= 1'b0;
      end
      if (deliver0) out0_count <= wrap_inc(out0_count);
    end
  end

  // Output register stage, channel 1
  always_ff @(posedge clk) begin
    if (reset) begin
      out1_data  <= '0;
      out1_valid <= 1'b0;
      out1_count <= '0;
    end else begin
      if (load1) begin
        out1_data  <= in_data;
        out1_valid <= 1'b1;
      end else if (deliver1) begin
        out1_valid <= 1'b0;
      end
      if (deliver1) out1_count <= wrap_inc(out1_count);
    end
  end

endmodule

// File: tb/tb_demux1to2_5bits_stream.sv
// Self-checking bench: queue-based channel model checked every cycle, directed scenarios
// with literal expectations, then constrained-random traffic with occasional resets.
module tb_demux1to2_5bits_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] in_data;
  logic       in_sel, in_valid, in_ready;
  logic [4:0] out0_data, out1_data;
  logic       out0_valid, out0_ready, out1_valid, out1_ready;
  logic [7:0] out0_count, out1_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: each channel is a queue of pending words (at most one), the last word
  // loaded into it, and the number of words handed to its consumer.
  logic [4:0] q0[$], q1[$];
  logic [4:0] last0, last1;
  logic [7:0] cnt0, cnt1;
  bit         last_acc;

  demux1to2_5bits_stream #(.WIDTH(5), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (reset) return 1'b0;
    if (in_sel) return (q1.size() == 0) || out1_ready;
    return (q0.size() == 0) || out0_ready;
  endfunction

  task automatic model_edge();
    bit acc;
    if (reset) begin
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0; cnt0 = '0; cnt1 = '0;
      last_acc = 1'b0;
      return;
    end
    acc = in_valid && model_ready();
    if (q0.size() != 0 && out0_ready) begin void'(q0.pop_front()); cnt0++; end
    if (q1.size() != 0 && out1_ready) begin void'(q1.pop_front()); cnt1++; end
    if (acc && !in_sel) begin q0.push_back(in_data); last0 = in_data; end
    if (acc &&  in_sel) begin q1.push_back(in_data); last1 = in_data; end
    last_acc = acc;
  endtask

  task automatic drive(input bit v, input bit s, input logic [4:0] d, input bit r0, input bit r1);
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",   int'(in_ready),   int'(model_ready()));
      check("out0_valid", int'(out0_valid), int'(q0.size() != 0));
      check("out1_valid", int'(out1_valid), int'(q1.size() != 0));
      check("out0_data",  int'(out0_data),  int'(last0));
      check("out1_data",  int'(out1_data),  int'(last1));
      check("out0_count", int'(out0_count), int'(cnt0));
      check("out1_count", int'(out1_count), int'(cnt1));
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_valid0", int'(out0_valid), 0);
    check("rst_count1", int'(out1_count), 0);

    // Load channel 0 and stall it
    reset = 1'b0;
    drive(1'b1, 1'b0, 5'b01100, 1'b0, 1'b0);
    #1 check("t1_ready", int'(in_ready), 1);
    tick();
    check("t1_valid0", int'(out0_valid), 1);
    check("t1_data0", int'(out0_data), 12);
    check("t1_valid1", int'(out1_valid), 0);
    drive(1'b1, 1'b0, 5'b01100, 1'b0, 1'b0);
    #1 check("t1_stall_ready", int'(in_ready), 0);
    tick();
    check("t1_hold0", int'(out0_data), 12);

    // Channel 1 proceeds while channel 0 stalls
    drive(1'b1, 1'b1, 5'b00110, 1'b0, 1'b0);
    #1 check("t2_ready", int'(in_ready), 1);
    tick();
    check("t2_data1", int'(out1_data), 6);
    check("t2_valid1", int'(out1_valid), 1);
    check("t2_data0", int'(out0_data), 12);

    // Streaming on channel 0 from a clean state
    reset = 1'b1; drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(); reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 5'(k), 1'b1, 1'b0);
      #1 check("t3_ready", int'(in_ready), 1);
      tick();
      check("t3_data0", int'(out0_data), k);
      check("t3_valid0", int'(out0_valid), 1);
    end
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    check("t3_count0", int'(out0_count), 4);
    check("t3_empty0", int'(out0_valid), 0);

    // Drain and refill in one cycle
    drive(1'b1, 1'b0, 5'd9, 1'b0, 1'b0); tick();
    check("t6_data9", int'(out0_data), 9);
    drive(1'b1, 1'b0, 5'd17, 1'b1, 1'b0);
    #1 check("t6_ready", int'(in_ready), 1);
    tick();
    check("t6_valid0", int'(out0_valid), 1);
    check("t6_data17", int'(out0_data), 17);
    check("t6_count0", int'(out0_count), 5);

    // Channel 1 counter wrap with channel 0 stalled
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 1'b1, 5'(k), 1'b0, 1'b1);
      tick();
    end
    check("t4_count1_255", int'(out1_count), 255);
    drive(1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
    tick();
    check("t4_count1_wrap", int'(out1_count), 0);
    check("t4_count0", int'(out0_count), 5);

    // Reset with both channels full and non-zero counts
    reset = 1'b1; drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b0, 5'(k), 1'b1, 1'b1); tick(); end
    for (int k = 0; k < 5; k++) begin drive(1'b1, 1'b1, 5'(k), 1'b1, 1'b1); tick(); end
    drive(1'b1, 1'b0, 5'd12, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b1, 5'd6, 1'b0, 1'b0); tick();
    check("t5_pre_count0", int'(out0_count), 3);
    check("t5_pre_count1", int'(out1_count), 5);
    check("t5_pre_data1", int'(out1_data), 6);
    reset = 1'b1;
    drive(1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    #1 check("t5_rst_ready", int'(in_ready), 0);
    tick();
    check("t5_valid0", int'(out0_valid), 0);
    check("t5_valid1", int'(out1_valid), 0);
    check("t5_data0", int'(out0_data), 0);
    check("t5_data1", int'(out1_data), 0);
    check("t5_count0", int'(out0_count), 0);
    check("t5_count1", int'(out1_count), 0);
    reset = 1'b0;

    // Random traffic; a presented word is held until accepted
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 4) != 0);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = 5'($urandom_range(0, 31));
      end
      tick();
    end

    chk_en = 1'b0;
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1to2_5bits_stream.md
Name: demux1to2_5bits_stream

Overview:
- Registered 1-to-2 stream demultiplexer; the inverse of the 2-to-1 5-bit mux path.
- Accepts one 5-bit data stream with a valid/ready handshake and steers each word to output 0 or output 1 according to a per-word selector.
- Each output has its own single-entry pipeline register, so one stalled consumer does not block words routed to the other consumer.
- Each output keeps a wrapping count of the words it has delivered.

Parameters:
- WIDTH, 5, data width of the input and both outputs.
- CNT_W, 8, width of each per-output delivered-word counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  destination for in_data: 0 = out0, 1 = out1.
- in_valid  input  1  in_data/in_sel are valid.
- in_ready  output  1  the block accepts the word this cycle.
- out0_data  output  WIDTH  channel-0 data register.
- out0_valid  output  1  channel-0 register holds an undelivered word.
- out0_ready  input  1  channel-0 consumer accepts.
- out1_data  output  WIDTH  channel-1 data register.
- out1_valid  output  1  channel-1 register holds an undelivered word.
- out1_ready  input  1  channel-1 consumer accepts.
- out0_count  output  CNT_W  channel-0 words delivered, modulo 2^CNT_W.
- out1_count  output  CNT_W  channel-1 words delivered, modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - outN_valid=0, outN_data=0, outN_count=0.
  - Any buffered word is discarded, including mid-transfer.
  - in_ready is 0 while reset is asserted.
- Per-channel state: EMPTY (outN_valid=0) or FULL (outN_valid=1).
- Channel N can take a word (free_N) when outN_valid=0, or when outN_valid=1 and outN_ready=1 (drain and refill in the same cycle).
- in_ready = !reset & (in_sel ? free_1 : free_0). This is combinational from in_sel and the selected outN_ready only; the unselected channel has no effect.
- Upstream rule: in_data and in_sel must stay stable while in_valid=1 && in_ready=0.
- Accept = in_valid & in_ready. On accept, for selected channel N: outN_data <= in_data and outN_valid <= 1.
- Latency: a word accepted at edge k appears at outN at edge k+1, so it is visible in the cycle after acceptance. There is no combinational path from in_data to outN_data.
- Deliver N = outN_valid & outN_ready:
  - If N is not also loaded that cycle, outN_valid <= 0.
  - outN_count <= outN_count+1, wrapping from 2^CNT_W-1 to 0.
- Simultaneous deliver and load on the same channel: outN_valid stays 1, outN_data takes the new word, and the count still increments. Full throughput is one word per cycle per channel.
- A word can be delivered on one channel while the other channel is loaded; both events happen in the same cycle.
- The unselected channel's register is never modified by an accept.
- When outN_valid=0, outN_data holds its last value (0 after reset). Consumers must ignore data while valid is 0.
- outN_valid=1 with outN_ready=0 holds outN_data and outN_valid stable until delivered.
- Words on each channel are delivered in acceptance order, with no loss or duplication.

Test Plan:
1. Release reset; in_data=5'b01100, in_sel=0, in_valid=1, out0_ready=0 for one cycle -> next cycle out0_valid=1, out0_data=12, out1_valid=0; while out0_ready=0 and in_sel=0, in_ready=0 and out0_data stays 12.
2. Channel 0 full and stalled (data 12); present in_data=5'b00110, in_sel=1 -> in_ready=1 and accept; next cycle out1_data=6, out1_valid=1, out0_data still 12.
3. Streaming: out0_ready=1 held, words 1,2,3,4 with in_sel=0 on consecutive cycles -> out0_data is 1,2,3,4 on consecutive cycles with valid never dropping; out0_count ends at 4; in_ready stays 1 throughout.
4. Counter wrap: deliver 256 words on channel 1 (CNT_W=8) -> out1_count returns to 0; out0_count is unchanged.
5. Reset mid-operation: both channels FULL (data 12 and 6, counts 3 and 5); assert reset for one edge -> all valid=0, data=0, counts=0, and in_ready=0 during reset.
6. Drain and refill in the same cycle: channel 0 holds 9, out0_ready=1, accept word 17 with in_sel=0 in that cycle -> next cycle out0_valid=1, out0_data=17, out0_count incremented by 1.
